// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with redirect/flush handling
module fetch_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h00003000,
    parameter logic [31:0] EXC_ADDR   = 32'h00004180
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [29:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_target,
    input  logic        exception,
    output logic [31:0] fetch_count
);

    localparam logic [29:0] RESET_PC = RESET_ADDR[31:2];
    localparam logic [29:0] EXC_PC   = EXC_ADDR[31:2];

    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic        pend_exc_q, pend_exc_d;
    logic [29:0] tgt_q, tgt_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redir;
    logic [29:0] redir_tgt;
    logic        handshake;
    logic        capture;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_exc_d    = pend_exc_q;
        tgt_d         = tgt_q;
        inst_data_d   = inst_data_q;
        fetch_count_d = fetch_count_q;

        redir     = exception | redirect_valid;
        redir_tgt = exception ? EXC_PC : redirect_target;
        handshake = (state_q == HOLD) & inst_ready;
        // A response is outstanding in REQ and in WAIT until imem_ready arrives
        capture   = (state_q == REQ) | ((state_q == WAIT) & ~imem_ready);

        if (handshake) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (capture) begin
            if (exception) begin
                pend_d     = 1'b1;
                pend_exc_d = 1'b1;
                tgt_d      = EXC_PC;
            end else if (redirect_valid && !(pend_q && pend_exc_q)) begin
                pend_d     = 1'b1;
                pend_exc_d = 1'b0;
                tgt_d      = redirect_target;
            end
        end

        case (state_q)
            BOOT: begin
                if (redir) begin
                    pc_d = redir_tgt;
                end
                state_d = REQ;
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (imem_ready) begin
                    if (redir) begin
                        pc_d    = redir_tgt;
                        pend_d  = 1'b0;
                        state_d = REQ;
                    end else if (pend_q) begin
                        pc_d    = tgt_q;
                        pend_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_data_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d    = redir_tgt;
                    state_d = REQ;
                end else if (handshake) begin
                    pc_d    = pc_q + 30'd1;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            pend_q        <= 1'b0;
            pend_exc_q    <= 1'b0;
            tgt_q         <= '0;
            inst_data_q   <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_exc_q    <= pend_exc_d;
            tgt_q         <= tgt_d;
            inst_data_q   <= inst_data_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign inst_valid  = (state_q == HOLD);
    assign inst_data   = inst_data_q;
    assign inst_pc     = pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_ADDR, default 32'h00003000, SHALL be the word-aligned boot fetch address.
REQ-002 Parameter EXC_ADDR, default 32'h00004180, SHALL be the exception vector fetch address.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  single-cycle fetch request to instruction memory.
REQ-007 imem_addr  output  30 [31:2]  word address of the request; equals pc.
REQ-008 imem_ready  input  1  one-cycle pulse, response data valid, at least 1 cycle after imem_req.
REQ-009 imem_rdata  input  32  instruction word, valid with imem_ready.
REQ-010 inst_valid  output  1  fetched instruction offered to decode.
REQ-011 inst_data  output  32  registered instruction word.
REQ-012 inst_pc  output  30 [31:2]  word address of inst_data.
REQ-013 inst_ready  input  1  decode accepts; handshake = inst_valid & inst_ready.
REQ-014 redirect_valid  input  1  branch/jump redirect request.
REQ-015 redirect_target  input  30 [31:2]  redirect word address.
REQ-016 exception  input  1  redirect to EXC_ADDR[31:2]; priority over redirect_valid.
REQ-017 fetch_count  output  32  count of completed decode handshakes.

Function
REQ-018 State machine states SHALL be BOOT, REQ, WAIT, HOLD.
REQ-019 imem_req SHALL be 1 only in REQ; inst_valid SHALL be 1 only in HOLD.
REQ-020 BOOT SHALL go to REQ unconditionally on the next clock.
REQ-021 REQ SHALL go to WAIT unconditionally.
REQ-022 WAIT SHALL stay until imem_ready; on imem_ready with no pending flush, it SHALL latch imem_rdata into inst_data and go to HOLD.
REQ-023 In HOLD with handshake and no redirect, pc SHALL become pc+1 modulo 2^30, with 30'h3FFFFFFF wrapping to 0, and the state SHALL go to REQ.
REQ-024 In HOLD without handshake, the state SHALL remain HOLD with inst_data and inst_pc stable.
REQ-025 The effective redirect target SHALL be EXC_ADDR[31:2] if exception, else redirect_target if redirect_valid.
REQ-026 A redirect in BOOT or HOLD SHALL load pc with the target and go to REQ.
REQ-027 A redirect in HOLD in the same cycle as a handshake SHALL count that instruction as accepted.
REQ-028 A redirect in REQ or WAIT SHALL set a pending-flush flag and store the target, because a memory response is outstanding.
REQ-029 On imem_ready with the pending flag set, the block SHALL discard the data, load pc with the stored target, clear the flag, and go to REQ.
REQ-030 A later redirect_valid while a flush is pending SHALL overwrite the stored target, unless the stored target came from exception.
REQ-031 A later exception SHALL always overwrite the stored target.
REQ-032 A redirect in the same cycle as imem_ready in WAIT SHALL discard the data and load pc with the new target directly.
REQ-033 fetch_count SHALL increment by 1 per handshake, wrapping at 2^32.
REQ-034 Fetch latency SHALL be: REQ, then WAIT for k cycles until imem_ready, then HOLD on the next cycle; minimum request-to-inst_valid latency is 2 cycles.

Reset
REQ-035 While reset=0, the outputs SHALL be: state=BOOT, pc=RESET_ADDR[31:2], pending flag=0, inst_data=0, fetch_count=0, imem_req=0, inst_valid=0.
REQ-036 Reset asserted mid-operation SHALL abort immediately; any memory response arriving after release and before the first REQ SHALL be ignored.

Verification
REQ-037 Boot: release reset, memory responds 1 cycle after each request, inst_ready=1 -> imem_addr sequence 0xC00, 0xC01, 0xC02 (byte 0x3000, 0x3004, 0x3008); fetch_count=3 after 3 handshakes.
REQ-038 Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst_data, inst_pc stable; no imem_req; fetch_count unchanged.
REQ-039 Flush in WAIT: redirect_valid with target 0x100 while the response is outstanding -> returned word dropped, inst_valid stays 0, next imem_addr=0x100.
REQ-040 Priority: exception and redirect_valid (target 0x200) in the same cycle, followed by redirect_valid (0x300) while pending -> next imem_addr=0x1060 (EXC_ADDR>>2).
REQ-041 Wrap: pc=30'h3FFFFFFF, handshake -> next imem_addr=0.
REQ-042 Reset mid-WAIT: reset pulsed low, then imem_ready arrives 1 cycle after release -> response ignored, first imem_addr=0xC00, fetch_count=0.
